// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//
// Dynamic conditional-branch predictor for the 5-stage MIPS core. A table of
// 2-bit saturating counters is read combinationally at fetch and trained at
// execute with the resolved outcome coming from the branch comparator.
//
// Optional feature (compile-time macro BRANCH_PREDICTOR_GSHARE_EN):
//   defined   -> gshare indexing: the PC slice is XORed with a global history
//                register that is updated non-speculatively at resolve time.
//   undefined -> the table index is the plain word-aligned PC slice.
//
// Parameters:
//   IDX_BITS  log2 of the number of table entries
//   CNT_INIT  counter value loaded on reset (weakly not-taken by default)
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   if_pc             fetch-stage PC
//   if_pred_taken     prediction for if_pc (combinational)
//   if_pred_idx       table index used for if_pc, carried down the pipe
//   ex_valid          EX holds a resolved conditional branch this cycle
//   ex_idx            index carried from fetch for that branch
//   ex_pred_taken     prediction carried from fetch
//   ex_br             actual outcome from the comparator (1 = taken)
//   ex_mispredict     registered one-cycle pulse for a mispredicted branch
//   stat_branches     saturating count of resolved branches
//   stat_mispredicts  saturating count of mispredictions
// ---------------------------------------------------------------------------
module branch_predictor #(
  parameter int unsigned IDX_BITS = 6,
  parameter logic [1:0]  CNT_INIT = 2'b01
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         if_pc,
  output logic                if_pred_taken,
  output logic [IDX_BITS-1:0] if_pred_idx,
  input  logic                ex_valid,
  input  logic [IDX_BITS-1:0] ex_idx,
  input  logic                ex_pred_taken,
  input  logic                ex_br,
  output logic                ex_mispredict,
  output logic [31:0]         stat_branches,
  output logic [31:0]         stat_mispredicts
);

  localparam int unsigned ENTRIES = 1 << IDX_BITS;

  logic [1:0]          pht [ENTRIES];
  logic [IDX_BITS-1:0] pc_idx;
  logic                mispredict;
  logic                unused_pc_bits;

  // Only the word-index bits of the PC select an entry; the rest are ignored.
  assign pc_idx         = if_pc[IDX_BITS+1:2];
  assign unused_pc_bits = ^{if_pc[31:IDX_BITS+2], if_pc[1:0]};

  assign mispredict = ex_pred_taken ^ ex_br;

`ifdef BRANCH_PREDICTOR_GSHARE_EN
  logic [IDX_BITS-1:0] ghr;

  // Global history shifts in resolved outcomes only, never speculative ones,
  // so it cannot be polluted by wrong-path fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr <= '0;
    end else if (ex_valid) begin
      ghr <= {ghr[IDX_BITS-2:0], ex_br};
    end
  end

  assign if_pred_idx = pc_idx ^ ghr;
`else
  assign if_pred_idx = pc_idx;
`endif

  // Read sees the stored counter only; a same-cycle update to the same entry
  // becomes visible on the following cycle (no bypass by design).
  assign if_pred_taken = pht[if_pred_idx][1];

  // Counter training: saturating increment on taken, decrement on not-taken.
  // The table lives in flops so that the whole array clears in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        pht[i] <= CNT_INIT;
      end
    end else if (ex_valid) begin
      if (ex_br) begin
        if (pht[ex_idx] != 2'b11) begin
          pht[ex_idx] <= pht[ex_idx] + 2'd1;
        end
      end else begin
        if (pht[ex_idx] != 2'b00) begin
          pht[ex_idx] <= pht[ex_idx] - 2'd1;
        end
      end
    end
  end

  // Mispredict flag for the flush logic, one cycle after resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_mispredict <= 1'b0;
    end else begin
      ex_mispredict <= ex_valid & mispredict;
    end
  end

  // Performance counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_branches    <= '0;
      stat_mispredicts <= '0;
    end else if (ex_valid) begin
      if (stat_branches != 32'hFFFF_FFFF) begin
        stat_branches <= stat_branches + 32'd1;
      end
      if (mispredict && (stat_mispredicts != 32'hFFFF_FFFF)) begin
        stat_mispredicts <= stat_mispredicts + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//
// Self-checking bench for branch_predictor: a table of directed vectors that
// walks through training, saturation, read-during-write and idle cycles, a
// few hand-written multi-cycle sequences (reset mid-training, history
// indexing), then randomized traffic compared against a behavioural model.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] if_pc;
  logic        if_pred_taken;
  logic [5:0]  if_pred_idx;
  logic        ex_valid;
  logic [5:0]  ex_idx;
  logic        ex_pred_taken;
  logic        ex_br;
  logic        ex_mispredict;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int total = 0;
  int bad   = 0;

  // Behavioural reference: plain integers for counters, history and stats.
  int     model_cnt [64];
  int     model_ghr;
  longint model_branches;
  longint model_mispredicts;
  int     model_mis;

  typedef struct {
    logic        valid;
    logic [5:0]  idx;
    logic        pred;
    logic        br;
    logic [31:0] pc;
    logic        exp_taken;
    logic [5:0]  exp_idx;
    logic        exp_mis;
    int          exp_branches;
    int          exp_mispredicts;
  } vec_t;

  vec_t vecs [13];

  branch_predictor #(
    .IDX_BITS (6),
    .CNT_INIT (2'b01)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .if_pc            (if_pc),
    .if_pred_taken    (if_pred_taken),
    .if_pred_idx      (if_pred_idx),
    .ex_valid         (ex_valid),
    .ex_idx           (ex_idx),
    .ex_pred_taken    (ex_pred_taken),
    .ex_br            (ex_br),
    .ex_mispredict    (ex_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Index the model expects for a fetch PC.
  function automatic int modelIndex(input logic [31:0] pc);
    int slice;
    slice = int'(pc / 4) % 64;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    return slice ^ model_ghr;
`else
    return slice;
`endif
  endfunction

  // Drive one cycle of inputs just after the falling edge.
  task automatic applyStimulus(input logic v, input logic [5:0] i, input logic p,
                               input logic b, input logic [31:0] pc, input logic r);
    @(negedge clk);
    ex_valid      = v;
    ex_idx        = i;
    ex_pred_taken = p;
    ex_br         = b;
    if_pc         = pc;
    rst           = r;
    #1;
  endtask

  // Advance the model with the inputs currently applied, then cross the edge.
  task automatic tick();
    int c;
    if (rst) begin
      for (int k = 0; k < 64; k++) model_cnt[k] = 1;
      model_ghr         = 0;
      model_branches    = 0;
      model_mispredicts = 0;
      model_mis         = 0;
    end else begin
      model_mis = (ex_valid && (ex_pred_taken != ex_br)) ? 1 : 0;
      if (ex_valid) begin
        c = model_cnt[ex_idx] + (ex_br ? 1 : -1);
        if (c > 3) c = 3;
        if (c < 0) c = 0;
        model_cnt[ex_idx] = c;
        if (model_branches < 64'hFFFF_FFFF) model_branches++;
        if (model_mis != 0 && model_mispredicts < 64'hFFFF_FFFF) model_mispredicts++;
        model_ghr = (model_ghr * 2 + int'(ex_br)) % 64;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkComb(input string tag);
    int mi;
    mi = modelIndex(if_pc);
    checkOutput({tag, "_idx"}, {26'd0, if_pred_idx}, mi);
    checkOutput({tag, "_pred"}, {31'd0, if_pred_taken}, (model_cnt[mi] >= 2) ? 1 : 0);
  endtask

  task automatic checkRegs(input string tag);
    checkOutput({tag, "_mis"}, {31'd0, ex_mispredict}, model_mis);
    checkOutput({tag, "_branches"}, stat_branches, model_branches[31:0]);
    checkOutput({tag, "_mispredicts"}, stat_mispredicts, model_mispredicts[31:0]);
  endtask

  initial begin
    logic [31:0] rpc;
    logic [31:0] pc_idx4_after_one_taken;
    logic [5:0]  exp_hist_idx;

    // Directed vectors (expected values assume plain PC indexing).
    vecs[0]  = '{1'b0, 6'd0, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 6'd4, 1'b0, 0, 0};
    vecs[1]  = '{1'b1, 6'd4, 1'b0, 1'b1, 32'h0040_0010, 1'b0, 6'd4, 1'b1, 1, 1};
    vecs[2]  = '{1'b1, 6'd4, 1'b0, 1'b1, 32'h0040_0010, 1'b1, 6'd4, 1'b1, 2, 2};
    vecs[3]  = '{1'b1, 6'd4, 1'b1, 1'b1, 32'h0040_0010, 1'b1, 6'd4, 1'b0, 3, 2};
    vecs[4]  = '{1'b1, 6'd4, 1'b1, 1'b1, 32'h0040_0010, 1'b1, 6'd4, 1'b0, 4, 2};
    vecs[5]  = '{1'b1, 6'd4, 1'b1, 1'b1, 32'h0040_0010, 1'b1, 6'd4, 1'b0, 5, 2};
    vecs[6]  = '{1'b1, 6'd4, 1'b1, 1'b0, 32'h0040_0010, 1'b1, 6'd4, 1'b1, 6, 3};
    vecs[7]  = '{1'b1, 6'd4, 1'b1, 1'b0, 32'h0040_0010, 1'b1, 6'd4, 1'b1, 7, 4};
    vecs[8]  = '{1'b0, 6'd4, 1'b0, 1'b0, 32'h0040_0010, 1'b0, 6'd4, 1'b0, 7, 4};
    vecs[9]  = '{1'b1, 6'd7, 1'b0, 1'b1, 32'h0040_001C, 1'b0, 6'd7, 1'b1, 8, 5};
    vecs[10] = '{1'b0, 6'd7, 1'b1, 1'b0, 32'h0040_001C, 1'b1, 6'd7, 1'b0, 8, 5};
    vecs[11] = '{1'b1, 6'd7, 1'b1, 1'b1, 32'h0040_001C, 1'b1, 6'd7, 1'b0, 9, 5};
    vecs[12] = '{1'b0, 6'd4, 1'b0, 1'b1, 32'h0040_0010, 1'b0, 6'd4, 1'b0, 9, 5};

    rst = 1'b1; ex_valid = 1'b0; ex_idx = '0; ex_pred_taken = 1'b0;
    ex_br = 1'b0; if_pc = '0;
    for (int k = 0; k < 64; k++) model_cnt[k] = 1;
    model_ghr = 0; model_branches = 0; model_mispredicts = 0; model_mis = 0;

    // Initial reset.
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 32'h0040_0010, 1'b1);
    tick();
    checkOutput("reset_mis", {31'd0, ex_mispredict}, 32'd0);
    checkOutput("reset_branches", stat_branches, 32'd0);
    checkOutput("reset_mispredicts", stat_mispredicts, 32'd0);

    // Directed vector table.
    for (int n = 0; n < 13; n++) begin
      applyStimulus(vecs[n].valid, vecs[n].idx, vecs[n].pred, vecs[n].br,
                    vecs[n].pc, 1'b0);
`ifdef BRANCH_PREDICTOR_GSHARE_EN
      checkComb($sformatf("vec%0d", n));
`else
      checkOutput($sformatf("vec%0d_idx", n), {26'd0, if_pred_idx}, {26'd0, vecs[n].exp_idx});
      checkOutput($sformatf("vec%0d_pred", n), {31'd0, if_pred_taken}, {31'd0, vecs[n].exp_taken});
`endif
      tick();
      checkOutput($sformatf("vec%0d_mis", n), {31'd0, ex_mispredict}, {31'd0, vecs[n].exp_mis});
      checkOutput($sformatf("vec%0d_branches", n), stat_branches, vecs[n].exp_branches);
      checkOutput($sformatf("vec%0d_mispredicts", n), stat_mispredicts, vecs[n].exp_mispredicts);
    end

    // Reset in the same cycle as a mispredicted update after training to 11.
    applyStimulus(1'b1, 6'd4, 1'b1, 1'b1, 32'h0040_0010, 1'b0);
    tick();
    applyStimulus(1'b1, 6'd4, 1'b1, 1'b1, 32'h0040_0010, 1'b0);
    tick();
    applyStimulus(1'b1, 6'd4, 1'b1, 1'b0, 32'h0040_0010, 1'b1);
    tick();
    checkOutput("rstmid_mis", {31'd0, ex_mispredict}, 32'd0);
    checkOutput("rstmid_branches", stat_branches, 32'd0);
    checkOutput("rstmid_mispredicts", stat_mispredicts, 32'd0);
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 32'h0040_001C, 1'b0);
    checkOutput("rstmid_idx7_pred", {31'd0, if_pred_taken}, 32'd0);
    tick();
    applyStimulus(1'b1, 6'd4, 1'b0, 1'b1, 32'h0040_0010, 1'b0);
    checkOutput("rstmid_idx4_pred", {31'd0, if_pred_taken}, 32'd0);
    tick();
    checkOutput("rstmid_train_mis", {31'd0, ex_mispredict}, 32'd1);
    checkOutput("rstmid_train_branches", stat_branches, 32'd1);
    // One taken step from the reset value 01 must reach 10 (predict taken).
`ifdef BRANCH_PREDICTOR_GSHARE_EN
    pc_idx4_after_one_taken = 32'h0040_0014;
    exp_hist_idx = 6'd7;
`else
    pc_idx4_after_one_taken = 32'h0040_0010;
    exp_hist_idx = 6'd4;
`endif
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, pc_idx4_after_one_taken, 1'b0);
    checkOutput("rstmid_idx4_after_pred", {31'd0, if_pred_taken}, 32'd1);
    checkOutput("rstmid_mis_pulse_end", {31'd0, ex_mispredict}, 32'd1);
    tick();
    checkOutput("rstmid_mis_cleared", {31'd0, ex_mispredict}, 32'd0);

    // History indexing: reset, two taken resolves, then look up idx-4 PC.
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 32'h0040_0010, 1'b1);
    tick();
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b1, 32'h0040_0010, 1'b0);
    tick();
    applyStimulus(1'b1, 6'd0, 1'b1, 1'b1, 32'h0040_0010, 1'b0);
    tick();
    applyStimulus(1'b0, 6'd0, 1'b0, 1'b0, 32'h0040_0010, 1'b0);
    checkOutput("hist_idx", {26'd0, if_pred_idx}, {26'd0, exp_hist_idx});
    tick();

    // Randomized traffic against the model, concentrated on a few entries.
    for (int n = 0; n < 600; n++) begin
      rpc      = $urandom;
      rpc[7:2] = 6'($urandom_range(7));
      applyStimulus(1'($urandom_range(3) != 0), 6'($urandom_range(7)),
                    1'($urandom), 1'($urandom_range(2) != 0), rpc,
                    1'($urandom_range(79) == 0));
      checkComb("rnd");
      tick();
      checkRegs("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Dynamic conditional-branch predictor for the 5-stage MIPS core.
- Fetch stage: looks up a taken/not-taken prediction from the fetch PC.
- Execute stage: receives the resolved outcome from the branch comparator (its br output), trains the pattern table and flags mispredictions for the flush logic.
- It is the predict/train counterpart of the comparator: the comparator produces outcomes, this block consumes them.

Parameters:
- IDX_BITS, 6, log2 of pattern-history-table entries (64 entries of 2-bit counters).
- CNT_INIT, 2'b01, counter value loaded on reset (weakly not-taken).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  32  fetch-stage PC.
- if_pred_taken  out  1  prediction for if_pc; combinational from the table.
- if_pred_idx  out  IDX_BITS  table index used for if_pc; carried down the pipe with the instruction.
- ex_valid  in  1  EX stage holds a resolved conditional branch this cycle.
- ex_idx  in  IDX_BITS  index carried from fetch for that branch.
- ex_pred_taken  in  1  prediction carried from fetch.
- ex_br  in  1  actual outcome from the comparator (1 = taken).
- ex_mispredict  out  1  registered one-cycle pulse: previous EX branch was mispredicted.
- stat_branches  out  32  count of resolved branches.
- stat_mispredicts  out  32  count of mispredictions.

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst, sampled on the rising edge.
- Reset: all table counters = CNT_INIT; ex_mispredict = 0; stat_branches = 0; stat_mispredicts = 0; global history (when present) = 0.
- Index: if_pred_idx = if_pc[IDX_BITS+1:2], so word-aligned PCs map directly.
- Prediction: if_pred_taken = table[if_pred_idx][1] (MSB of the counter). Purely combinational, zero latency.
- Counter update, at the rising edge when ex_valid = 1:
  - ex_br = 1: table[ex_idx] increments, saturating at 2'b11.
  - ex_br = 0: table[ex_idx] decrements, saturating at 2'b00.
  - ex_valid = 0: no table change.
- Read during write: if if_pred_idx == ex_idx in the same cycle, the prediction uses the pre-update counter. There is no bypass.
- Mispredict: ex_mispredict <= ex_valid & (ex_pred_taken ^ ex_br).
  - Latency 1 cycle; high for exactly one cycle per mispredicted branch.
  - Back-to-back mispredicts give consecutive high cycles.
- Statistics:
  - On ex_valid, stat_branches += 1.
  - On ex_valid & mispredict, stat_mispredicts += 1.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Reset priority: rst overrides any simultaneous update.
  - Reset mid-training restores all counters to CNT_INIT and clears the statistics and any pending ex_mispredict on the same edge.
- The table is held in flops, not BRAM, so reset-initialization is single-cycle.

Optional Feature:
- Macro: BRANCH_PREDICTOR_GSHARE_EN.
- Defined:
  - Adds an IDX_BITS-wide global history register ghr, reset to 0.
  - if_pred_idx = if_pc[IDX_BITS+1:2] ^ ghr.
  - On each ex_valid edge, ghr <= {ghr[IDX_BITS-2:0], ex_br}. History is updated non-speculatively, at resolve only.
  - Training uses ex_idx as supplied, so the pipeline must carry if_pred_idx.
- Undefined:
  - No ghr.
  - Index is the pure PC slice.
  - All other behaviour is identical.

Test Plan:
- Reset state: assert rst 1 cycle, then if_pc=32'h0040_0010 -> if_pred_idx=6'd4, if_pred_taken=0; both stats = 0; ex_mispredict = 0.
- Training with mispredict: ex_valid=1, ex_idx=4, ex_pred_taken=0, ex_br=1 for 2 consecutive cycles.
  - Counter goes 01 -> 10 -> 11.
  - if_pred_taken for idx 4 reads 1 from the cycle after the first update.
  - ex_mispredict is high for 2 cycles, starting 1 cycle after the first update.
  - stat_branches=2, stat_mispredicts=2.
- Saturation: 3 more taken updates at idx 4 keep the counter at 11. Then 2 not-taken updates (pred=1) -> counter 01, if_pred_taken=0, 2 mispredict pulses.
- Read during write: if_pc index = 7 and ex_idx = 7 with ex_br=1 in the same cycle, counter at 01 -> if_pred_taken=0 that cycle and 1 the next cycle.
- Correct prediction: ex_valid=1, ex_pred_taken=1, ex_br=1 -> ex_mispredict stays 0; stat_branches increments, stat_mispredicts unchanged. ex_valid=0 with any other inputs -> nothing changes.
- Reset mid-operation: train idx 4 to 11, then assert rst in the same cycle as a mispredicted update -> next cycle counter = 01, stats = 0, ex_mispredict = 0.
  - With BRANCH_PREDICTOR_GSHARE_EN defined: after taken, taken, if_pc=32'h0040_0010 -> if_pred_idx = 4 ^ 3 = 7.
